dct_frame_loader: RTL and testbench

- Upstream feeder for dct_top.
- Accepts a serial stream of M-bit samples with a valid/ready handshake and packs one frame (1..16 samples, delimited by s_last) into the packed parallel vector dct_top expects.
- Derives the number code, drives the start/ready handshake with dct_top, latches the coefficient vector, and presents it on a valid/ready result port.

---
 rtl/dct_pkg.sv | 27 ++
 rtl/dct_frame_loader_if.sv | 33 +++
 rtl/dct_frame_loader.sv | 138 +++++++++++++
 tb/tb_dct_frame_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types, limits and the number-code helper for the DCT frame loader.
package dct_pkg;

    typedef enum logic [2:0] {
        FILL,
        DROP,
        START,
        RELEASE,
        RESULT
    } state_t;

    localparam int N_MAX = 16;
    localparam int N_MIN = 8;
    localparam int CNT_W = 5;

    // Frames shorter than N_MIN are zero-padded to an N_MIN-point transform.
    function automatic logic [3:0] number_code(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] m;
        if (n < CNT_W'(N_MIN)) begin
            m = CNT_W'(N_MIN - 1);
        end else begin
            m = n - CNT_W'(1);
        end
        return m[3:0];
    endfunction

endpackage

// File: rtl/dct_frame_loader_if.sv
// Sample stream, dct_top start/ready link and result port of the frame loader.
interface dct_frame_loader_if
    import dct_pkg::*;
#(
    parameter int M = 32
);

    logic                 s_valid;
    logic                 s_ready;
    logic [M-1:0]         s_data;
    logic                 s_last;
    logic [M*N_MAX-1:0]   dct_data;
    logic [3:0]           dct_number;
    logic                 dct_start;
    logic                 dct_ready;
    logic [M*N_MAX-1:0]   dct_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [M*N_MAX-1:0]   res_data;
    logic [4:0]           res_len;
    logic                 trunc_err;

    modport slave (
        input  s_valid, s_data, s_last, dct_ready, dct_out, res_ready,
        output s_ready, dct_data, dct_number, dct_start, res_valid, res_data, res_len, trunc_err
    );

    modport master (
        output s_valid, s_data, s_last, dct_ready, dct_out, res_ready,
        input  s_ready, dct_data, dct_number, dct_start, res_valid, res_data, res_len, trunc_err
    );

endinterface

// File: rtl/dct_frame_loader.sv
// Packs a 1..16 sample frame for dct_top; start 1 cycle after close, result >=2 cycles after dct_ready.
// Backpressure: s_ready low from frame close until the result is accepted, so one frame is in flight.
module dct_frame_loader
    import dct_pkg::*;
#(
    parameter int M = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    dct_frame_loader_if.slave  bus
);

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          n_close;
    logic [N_MAX-1:0][M-1:0]   buffer;
    logic [N_MAX-1:0]          slot_we;
    logic                      s_ready_q;
    logic                      dct_start_q;
    logic                      res_valid_q;
    logic [3:0]                dct_number_q;
    logic [4:0]                res_len_q;
    logic [M*N_MAX-1:0]        res_data_q;
    logic                      trunc_err_q;
    logic                      accept;
    logic                      at_last_slot;
    logic                      buf_clr;

    assign accept       = bus.s_valid & s_ready_q;
    assign at_last_slot = (cnt == CNT_W'(N_MAX - 1));
    assign n_close      = cnt + CNT_W'(1);
    assign buf_clr      = (state == RESULT) && bus.res_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (bus.s_last) begin
                        state_nxt = START;
                    end else if (at_last_slot) begin
                        state_nxt = DROP;
                    end
                end
            end
            DROP:    if (accept && bus.s_last) state_nxt = START;
            START:   if (bus.dct_ready)        state_nxt = RELEASE;
            // A ready left over from the previous capture must clear before the result is exposed.
            RELEASE: if (!bus.dct_ready)       state_nxt = RESULT;
            RESULT:  if (bus.res_ready)        state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Handshake outputs are registered from the next state so they switch with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            s_ready_q   <= 1'b0;
            dct_start_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            s_ready_q   <= (state_nxt == FILL) || (state_nxt == DROP);
            dct_start_q <= (state_nxt == START);
            res_valid_q <= (state_nxt == RESULT);
        end
    end

    always_comb begin
        slot_we = '0;
        if ((state == FILL) && accept) begin
            slot_we[cnt[3:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
        end else begin
            for (int k = 0; k < N_MAX; k++) begin
                if (buf_clr) begin
                    buffer[k] <= '0;
                end else if (slot_we[k]) begin
                    buffer[k] <= bus.s_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dct_number_q <= 4'(N_MIN - 1);
            res_len_q    <= 5'(N_MIN);
            res_data_q   <= '0;
            trunc_err_q  <= 1'b0;
        end else begin
            trunc_err_q <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        cnt <= n_close;
                        if (bus.s_last || at_last_slot) begin
                            dct_number_q <= number_code(n_close);
                            res_len_q    <= (n_close <= CNT_W'(N_MIN)) ? 5'(N_MIN) : 5'(N_MAX);
                        end
                        if (!bus.s_last && at_last_slot) begin
                            trunc_err_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (bus.dct_ready) begin
                        res_data_q <= bus.dct_out;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.dct_start  = dct_start_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.dct_data   = buffer;
    assign bus.dct_number = dct_number_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_len    = res_len_q;
    assign bus.trunc_err  = trunc_err_q;

endmodule

// File: tb/tb_dct_frame_loader.sv
// Directed bench for dct_frame_loader with a small dct_top responder and a result scoreboard.
module tb_dct_frame_loader;

    localparam int M  = 32;
    localparam int WW = M * 16;
    typedef logic [WW-1:0] wide_t;

    typedef struct {
        wide_t      data;
        logic [3:0] num;
        logic [4:0] len;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];
    logic [M-1:0] smp[32];

    dct_frame_loader_if #(.M(M)) bus ();

    dct_frame_loader #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stand-in for dct_top: each coefficient is an affine map of its slot.
    function automatic wide_t dct_fn(input wide_t v);
        wide_t r;
        logic [M-1:0] s;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            s = v[k*M +: M];
            r[k*M +: M] = s * M'(3) + M'(k + 1);
        end
        return r;
    endfunction

    task automatic send_frame(input int n);
        wide_t exp_vec;
        exp_t  e;
        int    ne;
        int    tr;
        int    w;
        exp_vec = '0;
        ne = (n > 16) ? 16 : n;
        for (int i = 0; i < ne; i++) exp_vec[i*M +: M] = smp[i];
        tr = 0;
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = smp[i];
            bus.s_last  = (i == n - 1);
            w = 0;
            while (!bus.s_ready && w < 50) begin
                @(negedge clk);
                if (bus.trunc_err) tr++;
                w++;
            end
            if (w >= 50) chk("s_ready_timeout", wide_t'(0), wide_t'(1));
            @(negedge clk);
            if (bus.trunc_err) tr++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        e.data = exp_vec;
        e.num  = (ne < 8) ? 4'd7 : 4'(ne - 1);
        e.len  = (ne <= 8) ? 5'd8 : 5'd16;
        chk("start_latency", wide_t'(bus.dct_start), wide_t'(1));
        chk("dct_data", bus.dct_data, exp_vec);
        chk("dct_number", wide_t'(bus.dct_number), wide_t'(e.num));
        chk("trunc_pulses", wide_t'(tr), wide_t'((n > 16) ? 1 : 0));
        sb.push_back(e);
    endtask

    task automatic dct_hs(input int delay, input int stale);
        logic held;
        chk("s_ready_in_start", wide_t'(bus.s_ready), wide_t'(0));
        held = 1'b1;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            if (bus.dct_start !== 1'b1) held = 1'b0;
        end
        if (delay > 0) chk("start_held", wide_t'(held), wide_t'(1));
        bus.dct_out   = dct_fn(bus.dct_data);
        bus.dct_ready = 1'b1;
        @(negedge clk);
        chk("start_drop", wide_t'(bus.dct_start), wide_t'(0));
        for (int d = 0; d < stale; d++) begin
            @(negedge clk);
            chk("stale_ready_hold", wide_t'(bus.res_valid), wide_t'(0));
        end
        bus.dct_ready = 1'b0;
    endtask

    task automatic collect(input int hold, input bit pre);
        exp_t  e;
        wide_t exp_res;
        logic  ok;
        @(negedge clk);
        chk("res_valid", wide_t'(bus.res_valid), wide_t'(1));
        if (sb.size() == 0) begin
            chk("sb_underflow", wide_t'(0), wide_t'(1));
        end else begin
            e = sb.pop_front();
            exp_res = dct_fn(e.data);
            chk("res_data", bus.res_data, exp_res);
            chk("res_len", wide_t'(bus.res_len), wide_t'(e.len));
            chk("s_ready_in_result", wide_t'(bus.s_ready), wide_t'(0));
            if (!pre) begin
                ok = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    if (bus.res_valid !== 1'b1 || bus.res_data !== exp_res || bus.s_ready !== 1'b0) ok = 1'b0;
                end
                if (hold > 0) chk("result_hold_stable", wide_t'(ok), wide_t'(1));
                bus.res_ready = 1'b1;
            end
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("res_valid_drop", wide_t'(bus.res_valid), wide_t'(0));
        chk("s_ready_back", wide_t'(bus.s_ready), wide_t'(1));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.dct_ready = 1'b0;
        bus.dct_out   = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_s_ready", wide_t'(bus.s_ready), wide_t'(0));
        chk("rst_dct_start", wide_t'(bus.dct_start), wide_t'(0));
        chk("rst_res_valid", wide_t'(bus.res_valid), wide_t'(0));
        chk("rst_trunc_err", wide_t'(bus.trunc_err), wide_t'(0));
        chk("rst_dct_data", bus.dct_data, wide_t'(0));
        chk("rst_res_data", bus.res_data, wide_t'(0));
        chk("rst_dct_number", wide_t'(bus.dct_number), wide_t'(7));
        chk("rst_res_len", wide_t'(bus.res_len), wide_t'(8));

        rst_n = 1'b1;
        @(negedge clk);
        chk("fill_s_ready", wide_t'(bus.s_ready), wide_t'(1));

        // 8 samples, ready delayed by 4 cycles
        for (int i = 0; i < 8; i++) smp[i] = M'(i + 1);
        send_frame(8);
        dct_hs(4, 0);
        collect(0, 0);

        // 5 samples (zero-padded), stale ready held 3 cycles, result held off 10 cycles
        for (int i = 0; i < 5; i++) smp[i] = M'(10 * (i + 1));
        send_frame(5);
        dct_hs(1, 3);
        collect(10, 0);

        // 12 samples, consumer already ready when the result appears
        for (int i = 0; i < 12; i++) smp[i] = M'(32'hF000_0100 + i);
        send_frame(12);
        bus.res_ready = 1'b1;
        dct_hs(0, 0);
        collect(0, 1);

        // 20 samples: truncated to 16, tail dropped
        for (int i = 0; i < 20; i++) smp[i] = M'(i + 1);
        send_frame(20);
        dct_hs(2, 0);
        collect(0, 0);

        // exactly 16 samples with last: normal close
        for (int i = 0; i < 16; i++) smp[i] = M'(32'h8000_0000 | (i * 7));
        send_frame(16);
        dct_hs(0, 0);
        collect(0, 0);

        // reset while waiting in START
        for (int i = 0; i < 8; i++) smp[i] = M'(200 + i);
        send_frame(8);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dct_start", wide_t'(bus.dct_start), wide_t'(0));
        chk("midrst_res_valid", wide_t'(bus.res_valid), wide_t'(0));
        chk("midrst_s_ready", wide_t'(bus.s_ready), wide_t'(0));
        chk("midrst_dct_data", bus.dct_data, wide_t'(0));
        chk("midrst_dct_number", wide_t'(bus.dct_number), wide_t'(7));
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_s_ready", wide_t'(bus.s_ready), wide_t'(1));

        for (int i = 0; i < 8; i++) smp[i] = M'(32'hFFFF_FFF0 + i);
        send_frame(8);
        dct_hs(1, 0);
        collect(0, 0);

        chk("sb_empty", wide_t'(sb.size()), wide_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
